seq_gen_110: RTL and testbench
==============================

# seq_gen_110

Serial frame transmitter for the sequence-detector link: the driving end of the 1-bit serial line that the Moore "110"-family detectors monitor. It accepts parallel words over a valid/ready handshake. Each word goes out as a frame on one serial bit per clock: a fixed sync preamble followed by the data word, MSB first. The block sits between a word producer and the serial line feeding a detector.

## Interface
- DATA_W, 8: data word width in bits; legal range ≥ 2.
- SYNC_W, 3: preamble length in bits; legal range ≥ 1.
- SYNC_PAT, 3'b110: preamble pattern, transmitted MSB first.
- IDLE_LVL, 1'b0: line level when no frame is in flight.

- clk  input  1  system clock; all logic rises on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  DATA_W  word to transmit; sampled only on an accept.
- valid  input  1  producer has a word on data_in.
- ready  output  1  block can accept a word this cycle.
- x  output  1  serial line; registered.
- busy  output  1  a frame bit is on x this cycle.
- done  output  1  the last data bit of a frame is on x this cycle.

## Operation
- An accept occurs on a rising edge where valid && ready && !rst.
- State machine states:
  - IDLE: x = IDLE_LVL, busy = 0, ready = 1.
  - SYNC: shifts SYNC_PAT out, SYNC_W cycles.
  - DATA: shifts the latched word out, DATA_W cycles.
- Bit counter: width $clog2(max(SYNC_W, DATA_W)). It counts 0..SYNC_W-1 in SYNC and 0..DATA_W-1 in DATA. It clears on every state entry.
- IDLE transitions:
  - On accept: latch data_in into the shift register, x <= SYNC_PAT[SYNC_W-1], go to SYNC.
  - Otherwise: hold IDLE.
- SYNC transitions:
  - While cnt < SYNC_W-1: x <= next preamble bit.
  - At cnt == SYNC_W-1: x <= shift_reg[DATA_W-1], go to DATA.
- DATA, while cnt < DATA_W-1: shift left, x <= next MSB.
- DATA, at cnt == DATA_W-1 (last data bit on x):
  - ready = 1 and done = 1.
  - On accept: latch the new word, x <= SYNC_PAT[SYNC_W-1], go to SYNC. No idle gap between frames.
  - No accept: x <= IDLE_LVL, go to IDLE.
- ready is combinational: (state == IDLE) || (state == DATA && cnt == DATA_W-1). It never depends on valid.
- busy = (state != IDLE). done = (state == DATA && cnt == DATA_W-1).
- data_in is captured only at accept. Later changes to data_in do not affect the frame in flight.
- valid while ready = 0 is held off, not dropped. The producer must keep valid and data_in stable until accepted.

## Timing
- Reset: at a rising edge with rst = 1:
  - state = IDLE, cnt = 0, shift register = 0, x = IDLE_LVL.
  - Outputs after that edge: ready = 1, busy = 0, done = 0.
  - rst has priority over accept. valid during rst is ignored and not latched.
- Reset mid-frame aborts the frame immediately. The line returns to IDLE_LVL the cycle after the reset edge. No done is issued for an aborted frame.
- Latency: accept at edge k puts the first preamble bit on x in cycle k+1 (registered).
- Frame occupancy is SYNC_W + DATA_W cycles: preamble in cycles k+1..k+SYNC_W, data in cycles k+SYNC_W+1..k+SYNC_W+DATA_W.
- done is high for exactly one cycle per completed frame, aligned with the last data bit.
- Back-to-back throughput: one frame every SYNC_W + DATA_W cycles, 100% line utilisation.

## Test plan
- Single frame: reset, then valid with data_in = 8'hA5 in IDLE.
  - Required: accept that edge; x over the next 11 cycles = 1,1,0,1,0,1,0,0,1,0,1, then 0.
  - busy high for exactly 11 cycles; done high only on cycle 11.
- Back-to-back: valid held high with 8'hA5, changed to 8'h3C right after the first accept.
  - Required: second accept on the done cycle.
  - x continues with no gap: 1,1,0,0,0,1,1,1,1,0,0. 22 contiguous busy cycles, two done pulses.
- Hold-off: assert valid with 8'hFF in SYNC cycle 2, keep it held.
  - Required: no accept until the done cycle.
  - The frame in flight is unchanged; 8'hFF is sent next as 1,1,0,1,1,1,1,1,1,1,1.
- Data stability: change data_in every cycle after accepting 8'h81.
  - Required: data bits on x = 1,0,0,0,0,0,0,1.
- Reset mid-frame: rst = 1 for one edge during data bit 4 of 8'hA5.
  - Required: x = 0, ready = 1, busy = 0 next cycle; no done pulse.
  - A fresh accept of 8'h5A then gives 1,1,0,0,1,0,1,1,0,1,0.
- Reset priority: valid = 1 and rst = 1 on the same edge, in IDLE.
  - Required: no frame starts, x stays 0, ready = 1.
  - The frame starts at the first edge with rst = 0 and valid = 1.

Source files
------------

// File: rtl/seq_gen_110.sv
// seq_gen_110: serial frame transmitter.
// Each accepted word goes out as a sync preamble, then the data word MSB first.
module seq_gen_110 #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 3,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 3'b110,
    parameter logic              IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done
);

    localparam int MAXW = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CW   = $clog2(MAXW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [SYNC_W-1:0] r_pat;
    logic              r_x;

    logic w_last;
    logic w_acc;

    assign w_last = (r_state == S_DATA) && (r_cnt == CW'(DATA_W - 1));
    assign ready  = (r_state == S_IDLE) || w_last;
    assign busy   = (r_state != S_IDLE);
    assign done   = w_last;
    assign w_acc  = valid && ready;
    assign x      = r_x;

    // r_pat holds the preamble bits still to be sent, next bit in the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_pat   <= '0;
            r_x     <= IDLE_LVL;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_shift <= data_in;
                        r_pat   <= SYNC_PAT << 1;
                        r_x     <= SYNC_PAT[SYNC_W-1];
                        r_cnt   <= '0;
                        r_state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (r_cnt == CW'(SYNC_W - 1)) begin
                        r_x     <= r_shift[DATA_W-1];
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_x   <= r_pat[SYNC_W-1];
                        r_pat <= r_pat << 1;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (!w_last) begin
                        r_x     <= r_shift[DATA_W-2];
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt + CW'(1);
                    end else if (w_acc) begin
                        r_shift <= data_in;
                        r_pat   <= SYNC_PAT << 1;
                        r_x     <= SYNC_PAT[SYNC_W-1];
                        r_cnt   <= '0;
                        r_state <= S_SYNC;
                    end else begin
                        r_x     <= IDLE_LVL;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_x     <= IDLE_LVL;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_110.sv
// tb_seq_gen_110: directed checks of the serial frame transmitter.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_gen_110;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       x;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    seq_gen_110 dut (
        .clk    (clk),
        .rst    (rst),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .x      (x),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({x, ready, busy, done} !== 4'b0100) begin
            fails++;
            $display("FAIL reset x/ready/busy/done got=%b exp=0100",
                     {x, ready, busy, done});
        end
        @(negedge clk);
        tests++;
        if ({x, ready, busy, done} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=0100",
                     {x, ready, busy, done});
        end
    endtask

    task automatic test_single();
        logic [10:0] exp;
        exp     = {3'b110, 8'hA5};
        valid   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tests++;
            if ({x, busy, done} !== {exp[11-i], 1'b1, (i == 11)}) begin
                fails++;
                $display("FAIL single cyc=%0d x/busy/done got=%b exp=%b",
                         i, {x, busy, done}, {exp[11-i], 1'b1, (i == 11)});
            end
            @(negedge clk);
        end
        tests++;
        if ({x, ready, busy, done} !== 4'b0100) begin
            fails++;
            $display("FAIL single_end got=%b exp=0100",
                     {x, ready, busy, done});
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp;
        exp     = {3'b110, 8'hA5, 3'b110, 8'h3C};
        valid   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        data_in = 8'h3C;
        for (int i = 1; i <= 22; i++) begin
            if (i == 12) valid = 1'b0;
            tests++;
            if ({x, busy, done} !==
                {exp[22-i], 1'b1, (i == 11 || i == 22)}) begin
                fails++;
                $display("FAIL b2b cyc=%0d x/busy/done got=%b exp=%b",
                         i, {x, busy, done},
                         {exp[22-i], 1'b1, (i == 11 || i == 22)});
            end
            @(negedge clk);
        end
        tests++;
        if ({x, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL b2b_end got=%b exp=000", {x, busy, done});
        end
    endtask

    task automatic test_holdoff();
        logic [21:0] exp;
        exp     = {3'b110, 8'hA5, 3'b110, 8'hFF};
        valid   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            if (i == 2) begin
                valid   = 1'b1;
                data_in = 8'hFF;
            end
            if (i == 12) valid = 1'b0;
            tests++;
            if ({x, done} !== {exp[22-i], (i == 11 || i == 22)}) begin
                fails++;
                $display("FAIL holdoff cyc=%0d x/done got=%b exp=%b",
                         i, {x, done}, {exp[22-i], (i == 11 || i == 22)});
            end
            if (i <= 11) begin
                tests++;
                if (ready !== (i == 11)) begin
                    fails++;
                    $display("FAIL holdoff_ready cyc=%0d got=%b exp=%b",
                             i, ready, (i == 11));
                end
            end
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL holdoff_end busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_stability();
        logic [10:0] exp;
        exp     = {3'b110, 8'h81};
        valid   = 1'b1;
        data_in = 8'h81;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            data_in = 8'($urandom);
            tests++;
            if (x !== exp[11-i]) begin
                fails++;
                $display("FAIL stability cyc=%0d x got=%b exp=%b",
                         i, x, exp[11-i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp;
        int          dn;
        dn      = 0;
        valid   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i < 7; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({x, ready, busy, done} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_mid got=%b exp=0100",
                     {x, ready, busy, done});
        end
        repeat (6) begin
            if (done) dn++;
            @(negedge clk);
        end
        tests++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL reset_mid_done pulses got=%0d exp=0", dn);
        end
        exp     = {3'b110, 8'h5A};
        valid   = 1'b1;
        data_in = 8'h5A;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tests++;
            if (x !== exp[11-i]) begin
                fails++;
                $display("FAIL reset_mid_new cyc=%0d x got=%b exp=%b",
                         i, x, exp[11-i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_priority();
        logic [10:0] exp;
        exp     = {3'b110, 8'hC3};
        rst     = 1'b1;
        valid   = 1'b1;
        data_in = 8'hC3;
        @(negedge clk);
        tests++;
        if ({x, ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL rst_prio x/ready/busy got=%b exp=010",
                     {x, ready, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tests++;
            if ({x, busy} !== {exp[11-i], 1'b1}) begin
                fails++;
                $display("FAIL rst_prio_frame cyc=%0d x/busy got=%b exp=%b",
                         i, {x, busy}, {exp[11-i], 1'b1});
            end
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_prio_end busy got=%b exp=0", busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_holdoff();
        @(negedge clk);
        test_stability();
        @(negedge clk);
        test_reset_mid();
        @(negedge clk);
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
